// File: rtl/fetch_pkg.sv
// Types shared by the fetch stage and its instruction queue.
package fetch_pkg;
   import global_variables::*;

   localparam int INSTR_WIDTH = 32;

   typedef enum logic [1:0] {
      FETCH,
      MISS,
      STALL
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0]        address;
      logic [INSTR_WIDTH-1:0] instr;
   } queue_entry_t;
endpackage

// File: rtl/global_variables.sv
// Core-wide constants shared by every pipeline stage.
package global_variables;
   localparam int XLEN = 32;
endpackage

// File: rtl/instr_queue.sv
// Circular FIFO that takes 0-2 entries at the tail and releases 0-2 from the head each cycle.
// A synchronous clear empties it without touching the stored data.
module instr_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int PTRW = $clog2(DEPTH)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic [1:0]   pushCount,
   input  queue_entry_t pushEntry0,
   input  queue_entry_t pushEntry1,
   input  logic [1:0]   popCount,
   output queue_entry_t headEntry0,
   output queue_entry_t headEntry1,
   output logic [PTRW:0] count
);

   queue_entry_t    storage [DEPTH];
   logic [PTRW-1:0] headPtr;
   logic [PTRW-1:0] tailPtr;

   // Storage is zeroed on reset so head outputs never show X.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else if (clear) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (pushCount != 2'd0) begin
            storage[tailPtr] <= pushEntry0;
         end
         if (pushCount == 2'd2) begin
            storage[tailPtr + PTRW'(1)] <= pushEntry1;
         end
         tailPtr <= tailPtr + PTRW'(pushCount);
         headPtr <= headPtr + PTRW'(popCount);
         count   <= count + (PTRW+1)'(pushCount) - (PTRW+1)'(popCount);
      end
   end

   assign headEntry0 = storage[headPtr];
   assign headEntry1 = storage[headPtr + PTRW'(1)];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: requests the PC's doubleword from the I-cache, buffers instructions and steps the PC.
// Defining FETCH_PERF_CNT_EN adds saturating miss/stall cycle counters.
module instr_fetch_queue
   import global_variables::*;
   import fetch_pkg::*;
#(
   parameter int QUEUE_DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [XLEN-1:0]        pc_address,
   output logic                   pc_plus_4,
   output logic                   pc_plus_8,
   input  logic                   flush,
   output logic                   cache_req,
   output logic [XLEN-1:0]        cache_address,
   input  logic                   cache_hit,
   input  logic [63:0]            cache_data,
   output logic [1:0]             out_valid,
   output logic [INSTR_WIDTH-1:0] out_instr_0,
   output logic [INSTR_WIDTH-1:0] out_instr_1,
   output logic [XLEN-1:0]        out_address_0,
   output logic [XLEN-1:0]        out_address_1,
   input  logic [1:0]             out_take
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            perf_miss_cycles,
   output logic [31:0]            perf_stall_cycles
`endif
);

   localparam int PTRW = $clog2(QUEUE_DEPTH);

   fetch_state_t  state;
   fetch_state_t  stateNext;
   logic [PTRW:0] count;
   logic [PTRW:0] free;
   logic [1:0]    pushCount;
   queue_entry_t  pushEntry0;
   queue_entry_t  pushEntry1;
   queue_entry_t  headEntry0;
   queue_entry_t  headEntry1;

   // Free space is taken before this cycle's dequeue, so slots released by out_take count next cycle.
   assign free          = (PTRW+1)'(QUEUE_DEPTH) - count;
   assign cache_address = {pc_address[XLEN-1:3], 3'b000};

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= stateNext;
      end
   end

   // Flush and reset win over everything; a hit under flush is dropped.
   // An unaligned PC takes only the high word, which realigns later fetches to doublewords.
   always_comb begin
      stateNext  = state;
      cache_req  = 1'b0;
      pushCount  = 2'd0;
      pushEntry0 = '0;
      pushEntry1 = '0;
      pc_plus_4  = 1'b0;
      pc_plus_8  = 1'b0;

      unique case (state)
         FETCH: begin
            cache_req = (free != '0);
            if (free == '0) begin
               stateNext = STALL;
            end else if (!cache_hit) begin
               stateNext = MISS;
            end
         end
         MISS: begin
            cache_req = 1'b1;
            if (cache_hit) begin
               stateNext = FETCH;
            end
         end
         STALL: begin
            if (free != '0) begin
               stateNext = FETCH;
            end
         end
         default: stateNext = FETCH;
      endcase

      if (reset || flush) begin
         cache_req = 1'b0;
         stateNext = FETCH;
      end

      if (cache_req && cache_hit) begin
         if (pc_address[2]) begin
            pushCount  = 2'd1;
            pushEntry0 = '{address: pc_address, instr: cache_data[63:32]};
            pc_plus_4  = 1'b1;
         end else if (free >= (PTRW+1)'(2)) begin
            pushCount  = 2'd2;
            pushEntry0 = '{address: pc_address, instr: cache_data[31:0]};
            pushEntry1 = '{address: pc_address + XLEN'(4), instr: cache_data[63:32]};
            pc_plus_8  = 1'b1;
         end else begin
            pushCount  = 2'd1;
            pushEntry0 = '{address: pc_address, instr: cache_data[31:0]};
            pc_plus_4  = 1'b1;
         end
      end
   end

   instr_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) queue (
      .clock      (clock),
      .reset      (reset),
      .clear      (flush),
      .pushCount  (pushCount),
      .pushEntry0 (pushEntry0),
      .pushEntry1 (pushEntry1),
      .popCount   (out_take),
      .headEntry0 (headEntry0),
      .headEntry1 (headEntry1),
      .count      (count)
   );

   assign out_valid     = {count >= (PTRW+1)'(2), count != '0};
   assign out_instr_0   = headEntry0.instr;
   assign out_instr_1   = headEntry1.instr;
   assign out_address_0 = headEntry0.address;
   assign out_address_1 = headEntry1.address;

   // The decoder must never take more than it is shown.
   takeWithinValid: assert property (@(posedge clock) disable iff (reset)
      !flush |-> (out_take <= ({1'b0, out_valid[1]} + {1'b0, out_valid[0]})));

`ifdef FETCH_PERF_CNT_EN
   // Counters survive flushes; only reset clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_miss_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (state == MISS && perf_miss_cycles != '1) begin
            perf_miss_cycles <= perf_miss_cycles + 32'd1;
         end
         if (state == STALL && perf_stall_cycles != '1) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed fetch sequences, a PC model and a consuming monitor.
// The cache returns instrAt(addr) for every word, so each dequeued entry is checked by its address.
module tb_instr_fetch_queue;

   logic        clock;
   logic        reset;
   logic [31:0] pc_address;
   logic        pc_plus_4;
   logic        pc_plus_8;
   logic        flush;
   logic        cache_req;
   logic [31:0] cache_address;
   logic        cache_hit;
   logic [63:0] cache_data;
   logic [1:0]  out_valid;
   logic [31:0] out_instr_0;
   logic [31:0] out_instr_1;
   logic [31:0] out_address_0;
   logic [31:0] out_address_1;
   logic [1:0]  out_take;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_miss_cycles;
   logic [31:0] perf_stall_cycles;
   logic [31:0] missBase;
   logic [31:0] stallBase;
`endif

   logic        hitEnable;
   logic [31:0] jumpTarget;
   int          maxTake;
   logic [31:0] expectedAddr [$];
   int          checkCount = 0;
   int          passCount = 0;

   instr_fetch_queue dut (
      .clock         (clock),
      .reset         (reset),
      .pc_address    (pc_address),
      .pc_plus_4     (pc_plus_4),
      .pc_plus_8     (pc_plus_8),
      .flush         (flush),
      .cache_req     (cache_req),
      .cache_address (cache_address),
      .cache_hit     (cache_hit),
      .cache_data    (cache_data),
      .out_valid     (out_valid),
      .out_instr_0   (out_instr_0),
      .out_instr_1   (out_instr_1),
      .out_address_0 (out_address_0),
      .out_address_1 (out_address_1),
      .out_take      (out_take)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_miss_cycles  (perf_miss_cycles),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] instrAt(input logic [31:0] addr);
      return 32'h00100093 + (addr << 18);
   endfunction

   assign cache_hit  = hitEnable;
   assign cache_data = {instrAt(cache_address + 32'd4), instrAt(cache_address)};

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic hit, input logic fl, input logic [31:0] target);
      hitEnable  = hit;
      flush      = fl;
      jumpTarget = target;
      #1;
   endtask

   // PC register model: steps by what the DUT asked for at the edge just passed.
   task automatic nextCycle();
      logic p4, p8, fl;
      p4 = pc_plus_4;
      p8 = pc_plus_8;
      fl = flush;
      @(posedge clock);
      #1;
      if (reset)   pc_address = 32'h0;
      else if (fl) pc_address = jumpTarget;
      else if (p8) pc_address = pc_address + 32'd8;
      else if (p4) pc_address = pc_address + 32'd4;
   endtask

   // Monitor: consumes up to maxTake shown entries per cycle and checks them against the scoreboard.
   initial begin
      int          validCount;
      int          takeCount;
      logic [31:0] expAddr;
      out_take = 2'd0;
      forever begin
         @(negedge clock);
         validCount = int'(out_valid[0]) + int'(out_valid[1]);
         takeCount  = (reset || flush) ? 0 : ((maxTake < validCount) ? maxTake : validCount);
         for (int k = 0; k < takeCount; k++) begin
            if (expectedAddr.size() == 0) begin
               checkOutput("unexpectedEntry", (k == 0) ? out_address_0 : out_address_1, 32'hFFFF_FFFF);
            end else begin
               expAddr = expectedAddr.pop_front();
               checkOutput("dequeueAddress", (k == 0) ? out_address_0 : out_address_1, expAddr);
               checkOutput("dequeueInstr", (k == 0) ? out_instr_0 : out_instr_1, instrAt(expAddr));
            end
         end
         out_take = 2'(takeCount);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      flush      = 1'b0;
      hitEnable  = 1'b0;
      jumpTarget = 32'h0;
      maxTake    = 0;
      pc_address = 32'h0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("resetValid", 32'(out_valid), 32'h0);
      checkOutput("resetCacheReq", 32'(cache_req), 32'h0);
      checkOutput("resetPlus4", 32'(pc_plus_4), 32'h0);
      checkOutput("resetPlus8", 32'(pc_plus_8), 32'h0);
      checkOutput("resetInstr0", out_instr_0, 32'h0);
      checkOutput("resetAddress1", out_address_1, 32'h0);
      reset = 1'b0;

      $display("[TB] aligned dual fetch at 0x0");
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("dualPlus8", 32'(pc_plus_8), 32'h1);
      checkOutput("dualPlus4", 32'(pc_plus_4), 32'h0);
      checkOutput("dualCacheAddr", cache_address, 32'h0);
      expectedAddr.push_back(32'h0);
      expectedAddr.push_back(32'h4);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("dualValid", 32'(out_valid), 32'h3);
      checkOutput("dualAddress0", out_address_0, 32'h0);
      checkOutput("dualAddress1", out_address_1, 32'h4);
      checkOutput("dualInstr0", out_instr_0, 32'h00100093);
      checkOutput("dualInstr1", out_instr_1, 32'h00200093);
      nextCycle();

      $display("[TB] unaligned fetch at 0x4");
      applyStimulus(1'b1, 1'b1, 32'h4);
      checkOutput("flushCacheReq", 32'(cache_req), 32'h0);
      checkOutput("flushPlus8", 32'(pc_plus_8), 32'h0);
      nextCycle();
      expectedAddr.delete();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("highPlus4", 32'(pc_plus_4), 32'h1);
      checkOutput("highPlus8", 32'(pc_plus_8), 32'h0);
      checkOutput("highCacheAddr", cache_address, 32'h0);
      expectedAddr.push_back(32'h4);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("highValid", 32'(out_valid), 32'h1);
      checkOutput("highAddress0", out_address_0, 32'h4);
      checkOutput("highInstr0", out_instr_0, 32'h00200093);
      nextCycle();

      $display("[TB] three-cycle miss at 0x10");
      applyStimulus(1'b0, 1'b1, 32'h10);
      nextCycle();
      expectedAddr.delete();
`ifdef FETCH_PERF_CNT_EN
      missBase = perf_miss_cycles;
`endif
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkOutput("missCacheReq", 32'(cache_req), 32'h1);
         checkOutput("missCacheAddr", cache_address, 32'h10);
         checkOutput("missPlus4", 32'(pc_plus_4), 32'h0);
         checkOutput("missPlus8", 32'(pc_plus_8), 32'h0);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("missHitPlus8", 32'(pc_plus_8), 32'h1);
      checkOutput("missHitCacheAddr", cache_address, 32'h10);
      expectedAddr.push_back(32'h10);
      expectedAddr.push_back(32'h14);
      nextCycle();
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perfMissCycles", perf_miss_cycles - missBase, 32'd3);
`endif

      $display("[TB] fill to full, stall, partial refill");
      applyStimulus(1'b0, 1'b1, 32'h0);
      nextCycle();
      expectedAddr.delete();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkOutput("fillPlus8", 32'(pc_plus_8), 32'h1);
         expectedAddr.push_back(32'(8 * i));
         expectedAddr.push_back(32'(8 * i + 4));
         nextCycle();
      end
`ifdef FETCH_PERF_CNT_EN
      stallBase = perf_stall_cycles;
`endif
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("fullCacheReq", 32'(cache_req), 32'h0);
      checkOutput("fullPlus8", 32'(pc_plus_8), 32'h0);
      nextCycle();
      maxTake = 1;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stallCacheReq", 32'(cache_req), 32'h0);
      checkOutput("stallValid", 32'(out_valid), 32'h3);
      nextCycle();
      maxTake = 0;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stallExitCacheReq", 32'(cache_req), 32'h0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("oneFreeCacheReq", 32'(cache_req), 32'h1);
      checkOutput("oneFreePlus4", 32'(pc_plus_4), 32'h1);
      checkOutput("oneFreePlus8", 32'(pc_plus_8), 32'h0);
      checkOutput("oneFreeCacheAddr", cache_address, 32'h20);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perfStallCycles", perf_stall_cycles - stallBase, 32'd2);
`endif
      expectedAddr.push_back(32'h20);
      nextCycle();
      maxTake = 2;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("refullCacheReq", 32'(cache_req), 32'h0);
      nextCycle();
      maxTake = 1;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("drainStallCacheReq", 32'(cache_req), 32'h0);
      nextCycle();
      maxTake = 0;

      $display("[TB] flush with five queued and a hit");
      applyStimulus(1'b1, 1'b1, 32'h40);
      checkOutput("flushHitPlus4", 32'(pc_plus_4), 32'h0);
      checkOutput("flushHitPlus8", 32'(pc_plus_8), 32'h0);
      checkOutput("flushHitCacheReq", 32'(cache_req), 32'h0);
      checkOutput("flushHitValid", 32'(out_valid), 32'h3);
      checkOutput("flushHitHead", out_address_0, 32'h10);
      nextCycle();
      expectedAddr.delete();
      applyStimulus(1'b0, 1'b1, 32'h0);
      checkOutput("postFlushValid", 32'(out_valid), 32'h0);
      nextCycle();
      expectedAddr.delete();

      $display("[TB] streaming with wrap, two taken per cycle");
      maxTake = 2;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkOutput("streamPlus8", 32'(pc_plus_8), 32'h1);
         checkOutput("streamCacheAddr", cache_address, 32'(8 * i));
         expectedAddr.push_back(32'(8 * i));
         expectedAddr.push_back(32'(8 * i + 4));
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 20 && (expectedAddr.size() != 0 || out_valid != 2'b00); i++) begin
         nextCycle();
      end
      checkOutput("drainScoreboard", 32'(expectedAddr.size()), 32'h0);
      checkOutput("drainValid", 32'(out_valid), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter.
- Each cycle it requests the current PC address from the instruction cache and buffers up to two 32-bit instructions in a circular queue.
- It pulses the PC advance controls (plus_4 / plus_8) according to how many instructions it accepted.
- The decoder dequeues 0, 1 or 2 instructions per cycle from the queue head; a flush (jump redirect) empties the queue.

Parameters:
- XLEN, 32, address width (from global_variables)
- QUEUE_DEPTH, 8, queue entries; power of two, >= 4

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- pc_address  in  XLEN  current PC value
- pc_plus_4  out  1  PC advances by 4 at next edge
- pc_plus_8  out  1  PC advances by 8 at next edge
- flush  in  1  redirect; PC loads jump address at the same edge
- cache_req  out  1  instruction cache read request
- cache_address  out  XLEN  request address; equals pc_address with bits [2:0] cleared
- cache_hit  in  1  cache_data valid this cycle (combinational response)
- cache_data  in  64  [31:0] = word at base address, [63:32] = word at base+4
- out_valid  out  2  bit0 = head entry valid, bit1 = head+1 valid
- out_instr_0 / out_instr_1  out  32 each  head and head+1 instructions
- out_address_0 / out_address_1  out  XLEN each  their addresses
- out_take  in  2  number dequeued this cycle (0, 1 or 2); must be <= popcount(out_valid)

Behaviour:
- Reset: queue empty, state FETCH, and all outputs 0: out_valid, out_instr_*, out_address_*, cache_req, pc_plus_*.
- free = QUEUE_DEPTH - count. It is computed before this cycle's dequeue (conservative), so slots freed by out_take are usable next cycle.
- FSM:
  - FETCH: cache_req = (free >= 1) & ~flush.
  - MISS: entered when a request misses. cache_req is held at the same address until cache_hit.
  - STALL: entered when free == 0. cache_req = 0; returns to FETCH once free >= 1.
- Accept rules on cache_hit & cache_req:
  - pc_address[2] == 0 and free >= 2: push both words (addresses pc, pc+4); pc_plus_8 = 1.
  - pc_address[2] == 0 and free == 1: push the low word only; pc_plus_4 = 1.
  - pc_address[2] == 1: push the high word only (address pc); pc_plus_4 = 1. This realigns fetch.
- pc_plus_4 and pc_plus_8 are combinational, mutually exclusive, and never high without a push.
- MISS: no push and no plus pulses; returns to FETCH on the hit cycle, applying the accept rules on that cycle.
- Queue: entries written in order at the tail. out_* show the head and head+1 combinationally from storage.
  - Invalid slot data is don't-care, but X is never driven after reset.
  - Pointers wrap modulo QUEUE_DEPTH; count is one bit wider than the pointers.
- Simultaneous push and pop in one cycle: count_next = count + pushed - out_take.
- Flush (highest priority, overrides everything):
  - Queue emptied at the edge; any hit data that cycle is dropped.
  - pc_plus_* = 0 and cache_req = 0 in the flush cycle.
  - State goes to FETCH; fetching resumes the next cycle from the new PC.
  - out_take is ignored during flush.
- Reset while MISS is pending: the outstanding request is abandoned and state goes to FETCH.
- out_take greater than the valid count is illegal; it is checked by an assertion and has no defined effect.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: adds output ports perf_miss_cycles and perf_stall_cycles (32 bits each, saturating). They count cycles spent in MISS and STALL respectively; reset clears them to 0; flush does not clear them.
- When undefined: neither the ports nor the counters exist.

Decomposition:
- Shared package fetch_pkg:
  - INSTR_WIDTH = 32
  - fetch_state_t enum {FETCH, MISS, STALL}
  - queue_entry_t struct {address[XLEN], instr[32]}
- XLEN stays in global_variables.
- One sub-module, instr_queue: dual-push/dual-pop circular FIFO with synchronous clear. The FSM and accept logic stay in the top module.

Test Plan:
- Reset, then pc=0x0, hit with data {0x00200093, 0x00100093} -> cycle 1 pc_plus_8 = 1; next cycle out_valid = 2'b11, out_address_0 = 0x0, out_address_1 = 0x4, out_instr_0 = 0x00100093.
- pc=0x4, hit -> only the high word is pushed at address 0x4; pc_plus_4 = 1, pc_plus_8 = 0.
- Miss for 3 cycles at pc=0x10 -> cache_req held, cache_address = 0x10, no plus pulses; on the 4th-cycle hit, two entries are pushed and pc_plus_8 = 1.
- QUEUE_DEPTH=8, out_take=0, continuous hits -> count 8 after 4 fetches, then STALL with cache_req = 0. With 7 entries queued, the next hit pushes only the low word and pulses pc_plus_4.
- Queue holds 5 entries, flush asserted together with a hit -> next cycle out_valid = 0 and no entry from the hit is present; pc_plus_* = 0 during flush.
- Wrap check: 20 fetches with out_take = 2 every cycle -> addresses 0x0..0x4C dequeued in order, no loss or duplication. With FETCH_PERF_CNT_EN defined, perf_miss_cycles and perf_stall_cycles match the injected miss and stall cycles exactly.
